// File: rtl/alu_pkg.sv
// Shared definitions for the SIMD saturating adder: lane-width encodings,
// per-lane saturation limits and the per-lane add helpers used by the alu.
package alu_pkg;

    localparam logic [1:0] W8  = 2'b00;
    localparam logic [1:0] W16 = 2'b01;
    localparam logic [1:0] W32 = 2'b10;

    localparam logic [7:0]  SAT8_POS  = 8'h7F;
    localparam logic [7:0]  SAT8_NEG  = 8'h80;
    localparam logic [15:0] SAT16_POS = 16'h7FFF;
    localparam logic [15:0] SAT16_NEG = 16'h8000;
    localparam logic [31:0] SAT32_POS = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT32_NEG = 32'h8000_0000;

    // Overflow is detected from operand and result sign bits only.
    function automatic logic [7:0] add8(input logic [7:0] a, input logic [7:0] b, input logic sat);
        logic [7:0] s;
        s = a + b;
        if (sat && a[7] && b[7] && !s[7]) begin
            return SAT8_NEG;
        end else if (sat && !a[7] && !b[7] && s[7]) begin
            return SAT8_POS;
        end else begin
            return s;
        end
    endfunction

    function automatic logic [15:0] add16(input logic [15:0] a, input logic [15:0] b, input logic sat);
        logic [15:0] s;
        s = a + b;
        if (sat && a[15] && b[15] && !s[15]) begin
            return SAT16_NEG;
        end else if (sat && !a[15] && !b[15] && s[15]) begin
            return SAT16_POS;
        end else begin
            return s;
        end
    endfunction

    function automatic logic [31:0] add32(input logic [31:0] a, input logic [31:0] b, input logic sat);
        logic [31:0] s;
        s = a + b;
        if (sat && a[31] && b[31] && !s[31]) begin
            return SAT32_NEG;
        end else if (sat && !a[31] && !b[31] && s[31]) begin
            return SAT32_POS;
        end else begin
            return s;
        end
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational SIMD adder: 4x8, 2x16 or 1x32 lanes, wrap or signed saturation.
// Each lane has its own adder so no carry ever crosses a lane edge.
module alu
    import alu_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [1:0]  i_width,
    input  logic        i_sat,
    output logic [31:0] o_sum
);

    logic [31:0] w_sum8;
    logic [31:0] w_sum16;
    logic [31:0] w_sum32;

    for (genvar l = 0; l < 4; l++) begin : g_lane8
        assign w_sum8[l*8 +: 8] = add8(i_a[l*8 +: 8], i_b[l*8 +: 8], i_sat);
    end

    for (genvar l = 0; l < 2; l++) begin : g_lane16
        assign w_sum16[l*16 +: 16] = add16(i_a[l*16 +: 16], i_b[l*16 +: 16], i_sat);
    end

    assign w_sum32 = add32(i_a, i_b, i_sat);

    // Lane-width select; both 2'b10 and 2'b11 mean a single 32-bit lane.
    always_comb begin
        o_sum = w_sum32;
        case (i_width)
            W8:      o_sum = w_sum8;
            W16:     o_sum = w_sum16;
            W32:     o_sum = w_sum32;
            default: o_sum = w_sum32;
        endcase
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin arbiter sharing one alu among NREQ requesters; the winner's result
// is registered with its index on a single valid/ready response port.
module alu_rr_scheduler
    import alu_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [32*NREQ-1:0] req_a,
    input  logic [32*NREQ-1:0] req_b,
    input  logic [2*NREQ-1:0]  req_width,
    input  logic [NREQ-1:0]    req_sat,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [31:0]        rsp_data,
    output logic [IDW-1:0]     rsp_id
);

    logic           r_rsp_valid;
    logic [31:0]    r_rsp_data;
    logic [IDW-1:0] r_rsp_id;
    logic [IDW-1:0] r_prio;

    logic            w_can_issue;
    logic            w_found;
    logic            w_fire;
    logic [IDW-1:0]  w_grant;
    logic [IDW-1:0]  w_prio_next;
    logic [NREQ-1:0] w_ready;
    logic [31:0]     w_a;
    logic [31:0]     w_b;
    logic [1:0]      w_width;
    logic            w_sat;
    logic [31:0]     w_sum;

    // Scanning from the far end lets the closest hit to prio overwrite later ones.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid, input logic [IDW-1:0] prio);
        logic [IDW:0] pick;
        int           idx;
        pick = {(IDW+1){1'b0}};
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(prio) + k) % NREQ;
            if (valid[idx]) begin
                pick = {1'b1, IDW'(idx)};
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // Arbitration, grant vector and operand mux for the shared alu.
    always_comb begin
        w_can_issue        = !r_rsp_valid || rsp_ready;
        {w_found, w_grant} = rr_pick(req_valid, r_prio);
        w_ready            = {NREQ{1'b0}};
        if (rst_n && w_can_issue && w_found) begin
            w_ready[w_grant] = 1'b1;
        end else begin
            w_ready = {NREQ{1'b0}};
        end
        w_fire  = |(req_valid & w_ready);
        w_a     = req_a[32*int'(w_grant) +: 32];
        w_b     = req_b[32*int'(w_grant) +: 32];
        w_width = req_width[2*int'(w_grant) +: 2];
        w_sat   = req_sat[w_grant];
        if (w_grant == IDW'(NREQ - 1)) begin
            w_prio_next = {IDW{1'b0}};
        end else begin
            w_prio_next = w_grant + IDW'(1);
        end
    end

    alu u_alu (
        .i_a     (w_a),
        .i_b     (w_b),
        .i_width (w_width),
        .i_sat   (w_sat),
        .o_sum   (w_sum)
    );

    // Result register and round-robin pointer; everything holds under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'h0;
            r_rsp_id    <= {IDW{1'b0}};
            r_prio      <= {IDW{1'b0}};
        end else if (w_can_issue) begin
            if (w_fire) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= w_sum;
                r_rsp_id    <= w_grant;
                r_prio      <= w_prio_next;
            end else begin
                r_rsp_valid <= 1'b0;
            end
        end else begin
            r_rsp_valid <= r_rsp_valid;
        end
    end

    assign req_ready = w_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Self-checking bench for alu_rr_scheduler: directed vector table, scoreboard
// with an independent arbiter/adder model, and multi-cycle corner sequences.
module tb_alu_rr_scheduler;
    import alu_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int NV   = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_ready;
    logic [32*NREQ-1:0] req_a = '0;
    logic [32*NREQ-1:0] req_b = '0;
    logic [2*NREQ-1:0]  req_width = '0;
    logic [NREQ-1:0]    req_sat = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic [31:0]        rsp_data;
    logic [IDW-1:0]     rsp_id;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  width;
        logic        sat;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [IDW-1:0] id;
        logic [31:0]    data;
    } exp_t;

    vec_t           vt [NV];
    exp_t           sb [$];
    int             obs_ids [$];
    int             n_cmp = 0;
    int             n_err = 0;
    logic [IDW-1:0] m_prio = '0;
    logic           m_valid = 1'b0;

    alu_rr_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_width (req_width),
        .req_sat   (req_sat),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference adder: signed integer arithmetic per lane, then clamp or truncate.
    function automatic logic [31:0] m_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] wd, input logic sat);
        int          w;
        logic [31:0] r;
        longint      mask, hi, lo, va, vb, s;
        w    = (wd == 2'b00) ? 8 : ((wd == 2'b01) ? 16 : 32);
        r    = 32'h0;
        mask = (longint'(1) <<< w) - 1;
        hi   = (longint'(1) <<< (w - 1)) - 1;
        lo   = -(hi + 1);
        for (int l = 0; l < 32 / w; l++) begin
            va = longint'(a >> (l * w)) & mask;
            vb = longint'(b >> (l * w)) & mask;
            if (va > hi) va = va - (mask + 1);
            if (vb > hi) vb = vb - (mask + 1);
            s = va + vb;
            if (sat && s > hi) s = hi;
            else if (sat && s < lo) s = lo;
            r = r | (32'(s & mask) << (l * w));
        end
        return r;
    endfunction

    task automatic mon_step();
        logic            can;
        logic            found;
        int              g;
        int              idx;
        logic [NREQ-1:0] exp_rdy;
        exp_t            e;
        if (!rst_n) begin
            check("rst_req_ready", 32'(req_ready), 32'h0);
            check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
            check("rst_rsp_data", rsp_data, 32'h0);
            check("rst_rsp_id", 32'(rsp_id), 32'h0);
            m_prio  = '0;
            m_valid = 1'b0;
            sb.delete();
        end else begin
            can   = !m_valid || rsp_ready;
            found = 1'b0;
            g     = 0;
            if (can) begin
                for (int k = 0; k < NREQ; k++) begin
                    idx = (int'(m_prio) + k) % NREQ;
                    if (!found && req_valid[idx]) begin
                        found = 1'b1;
                        g     = idx;
                    end
                end
            end
            exp_rdy = found ? (NREQ'(1) << g) : '0;
            check("req_ready", 32'(req_ready), 32'(exp_rdy));
            check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
            if (m_valid) begin
                if (sb.size() == 0) begin
                    check("sb_nonempty", 32'(0), 32'(1));
                end else begin
                    check("sb_data", rsp_data, sb[0].data);
                    check("sb_id", 32'(rsp_id), 32'(sb[0].id));
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                        obs_ids.push_back(int'(rsp_id));
                    end
                end
            end
            if (found) begin
                e.id   = IDW'(g);
                e.data = m_alu(req_a[g*32 +: 32], req_b[g*32 +: 32], req_width[g*2 +: 2], req_sat[g]);
                sb.push_back(e);
                m_prio  = IDW'((g + 1) % NREQ);
                m_valid = 1'b1;
            end else if (can) begin
                m_valid = 1'b0;
            end
        end
    endtask

    always @(negedge clk) mon_step();

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] w, input logic s);
        req_a[id*32 +: 32]   = a;
        req_b[id*32 +: 32]   = b;
        req_width[id*2 +: 2] = w;
        req_sat[id]          = s;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{2, 32'h7F7F7F7F, 32'h01010101, W8,    1'b1, 32'h7F7F7F7F};
        vt[1] = '{2, 32'h7F7F7F7F, 32'h01010101, W8,    1'b0, 32'h80808080};
        vt[2] = '{0, 32'h80008000, 32'hFFFFFFFF, W16,   1'b1, 32'h80008000};
        vt[3] = '{1, 32'h80008000, 32'hFFFFFFFF, W32,   1'b0, 32'h80007FFF};
        vt[4] = '{3, 32'h80008000, 32'hFFFFFFFF, W32,   1'b1, 32'h80007FFF};
        vt[5] = '{1, 32'h80808080, 32'h80808080, W8,    1'b1, 32'h80808080};
        vt[6] = '{3, 32'h00FF00FF, 32'h00010001, W8,    1'b0, 32'h00000000};
        vt[7] = '{0, 32'h7FFFFFFF, 32'h00000001, 2'b11, 1'b1, 32'h7FFFFFFF};

        // Reset and idle
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("idle_rsp_valid", 32'(rsp_valid), 32'h0);
        check("idle_rsp_data", rsp_data, 32'h0);
        check("idle_req_ready", 32'(req_ready), 32'h0);

        // Fairness: all requesters valid for 8 cycles
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        for (int s = 0; s < NREQ; s++) set_req(s, $urandom, $urandom, 2'($urandom), 1'($urandom));
        obs_ids.delete();
        req_valid = '1;
        repeat (8) @(posedge clk);
        #1 req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        check("fair_count", 32'(obs_ids.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < obs_ids.size()) check("fair_seq", 32'(obs_ids[i]), 32'(i % NREQ));
        end

        // Directed vector table, single requester each
        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            set_req(vt[i].id, vt[i].a, vt[i].b, vt[i].width, vt[i].sat);
            req_valid = NREQ'(1) << vt[i].id;
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            req_valid = '0;
            @(negedge clk);
            check("tbl_valid", 32'(rsp_valid), 32'h1);
            check("tbl_data", rsp_data, vt[i].exp);
            check("tbl_id", 32'(rsp_id), 32'(vt[i].id));
        end

        // Backpressure: result from requester 1 held while 1 and 2 wait
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        set_req(1, 32'h00010002, 32'h00030004, W16, 1'b0);
        req_valid = 4'b0010;
        @(posedge clk); #1;
        set_req(2, 32'h11111111, 32'h22222222, W8, 1'b0);
        req_valid = 4'b0110;
        repeat (3) begin
            @(negedge clk);
            check("bp_req_ready", 32'(req_ready), 32'h0);
            check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
            check("bp_rsp_data", rsp_data, 32'h00040006);
            check("bp_rsp_id", 32'(rsp_id), 32'h1);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_grant", 32'(req_ready), 32'h4);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("bp_next_valid", 32'(rsp_valid), 32'h1);
        check("bp_next_id", 32'(rsp_id), 32'h2);
        check("bp_next_data", rsp_data, 32'h33333333);

        // Mid-operation reset with a pending result
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        set_req(3, 32'h01020304, 32'h01010101, W8, 1'b1);
        set_req(1, 32'h00000005, 32'h00000007, W32, 1'b0);
        req_valid = 4'b1000;
        @(posedge clk); #1;
        req_valid = 4'b1010;
        @(negedge clk);
        check("mid_pending", 32'(rsp_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_async_drop", 32'(rsp_valid), 32'h0);
        check("mid_rst_ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("post_rst_grant", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("post_rst_id", 32'(rsp_id), 32'h1);
        check("post_rst_data", rsp_data, 32'h0000000C);

        // Random traffic, checked by the scoreboard
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            req_valid = NREQ'($urandom);
            for (int s = 0; s < NREQ; s++) set_req(s, $urandom, $urandom, 2'($urandom), 1'($urandom));
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
